eth_phy_10g_rx_bitslip: RTL
===========================

Name: eth_phy_10g_rx_bitslip

Overview:
- Soft bit-slip aligner that sits directly upstream of the 10GBASE-R RX frame sync stage.
- Takes raw, unaligned 66-bit words from the SERDES (64 data + 2 header bits per cycle) and outputs a 66-bit window.
- The frame sync stage drives the slip request; each request moves the window start by one bit until sync headers land on the header lane.
- Used on transceivers without a native bitslip port.

Parameters:
- DATA_WIDTH, 64, data lane width; must be 64 (elaboration error otherwise).
- HDR_WIDTH, 2, header lane width; must be 2 (elaboration error otherwise).
- BIT_REVERSE, 0, when 1, bit-reverse each input lane before processing and each output lane after processing.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- serdes_rx_data_in  input  DATA_WIDTH  raw SERDES data, unaligned
- serdes_rx_hdr_in  input  HDR_WIDTH  raw SERDES header lane, unaligned
- serdes_rx_valid_in  input  1  raw word valid (gearbox pacing); tie high if unused
- serdes_rx_bitslip  input  1  slip request, one-cycle pulse from frame sync
- serdes_rx_data  output  DATA_WIDTH  aligned data
- serdes_rx_hdr  output  HDR_WIDTH  aligned header
- serdes_rx_valid  output  1  aligned word valid
- slip_offset  output  7  current window offset, 0..65

Behaviour:
- Input word: W = {data_in, hdr_in}, 66 bits. W[1:0] is the header and is the earliest-received bit pair; bit 0 is first on the wire.
- Registers: prev_reg (66b), offset_reg (7b).
- Window: B = {W, prev_reg}, 132 bits. Aligned block A = B[offset_reg +: 66].
- Output split: serdes_rx_hdr = A[1:0], serdes_rx_data = A[65:2].
- When serdes_rx_valid_in = 1, all of the following happen on the clock edge:
  - prev_reg <= W
  - output data/hdr registers <= A
  - serdes_rx_valid <= 1
- When serdes_rx_valid_in = 0:
  - prev_reg and the output data/hdr registers hold.
  - serdes_rx_valid <= 0.
- Latency: with offset 0, the word presented on input at cycle N appears on the output after the next valid input word.
  - Continuous valid: word N is output at cycle N+2 (registered).
- Slip: serdes_rx_bitslip = 1 in any cycle sets offset_reg <= (offset_reg == 65) ? 0 : offset_reg + 1.
  - Accepted regardless of serdes_rx_valid_in.
  - Effective from the next clock edge; the output computed in the same cycle uses the old offset.
  - Multi-cycle high counts one slip per cycle. Frame sync blanking guarantees pulses, but the block must not rely on it.
- Wrap 65 -> 0 is intentional: the output is equivalent to offset 66 delayed by one word (one block duplicated). This is tolerated because frame sync is unlocked while slipping.
- slip_offset = offset_reg, combinational from the register.
- Reset (synchronous, rst = 1), including mid-stream:
  - prev_reg = 0, offset_reg = 0, serdes_rx_data = 0, serdes_rx_hdr = 0, serdes_rx_valid = 0.
  - Slip and valid inputs are ignored during reset.
  - The first valid output after reset deasserts contains zeros in the bits taken from prev_reg.
- BIT_REVERSE = 1: reversal is per lane, applied to both input and output, so offset semantics are unchanged in wire order.
- No combinational path from any input to any output.

Test Plan:
- Reset, valid_in = 1, input hdr = 2'b01, data = 64'h0123456789ABCDEF every cycle, no slip -> from the 2nd output cycle on, serdes_rx_hdr = 01, serdes_rx_data = 64'h0123456789ABCDEF, valid = 1, slip_offset = 0.
- Stream of 66b blocks with alternating headers 01/10, pre-rotated by 5 bits; five single-cycle slip pulses 4 cycles apart -> slip_offset = 5, output headers alternate 01/10, and data matches the original blocks.
- 66 slip pulses from offset 0 -> slip_offset sequence 1..65 then 0; no X and no stall on the output.
- valid_in pattern 1,0,1,1,0 with a constant stream -> prev_reg and outputs hold on 0 cycles, valid_out follows 0,1,0,1,1 (1-cycle lag), and data does not skip words.
- Slip asserted in the same cycle as a valid word at offset 3 -> the output of that edge uses offset 3, the next uses offset 4.
- Reset asserted mid-stream at offset 20 -> next cycle slip_offset = 0, valid = 0, data = 0, hdr = 0; after release, behaviour matches scenario 1.

Source files
------------

// File: rtl/eth_phy_10g_rx_bitslip.sv
// Soft bit-slip aligner for the 10GBASE-R receive path.
//
// Sits between a SERDES without a native bitslip port and the frame sync
// stage. Each raw 66-bit word {data, hdr} is joined with the previous word to
// form a 132-bit window, and a 66-bit block is picked from it at the current
// slip offset. Every slip request moves the window start one bit later.
//
// Ports:
//   clk                 clock
//   rst                 synchronous active-high reset
//   serdes_rx_data_in   raw SERDES data lane, unaligned
//   serdes_rx_hdr_in    raw SERDES header lane, unaligned
//   serdes_rx_valid_in  raw word valid (gearbox pacing)
//   serdes_rx_bitslip   slip request from frame sync, one slip per high cycle
//   serdes_rx_data      aligned data lane (registered)
//   serdes_rx_hdr       aligned header lane (registered)
//   serdes_rx_valid     aligned word valid (registered)
//   slip_offset         current window offset, 0..65
module eth_phy_10g_rx_bitslip #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned HDR_WIDTH   = 2,
  parameter bit          BIT_REVERSE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] serdes_rx_data_in,
  input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr_in,
  input  logic                  serdes_rx_valid_in,
  input  logic                  serdes_rx_bitslip,
  output logic [DATA_WIDTH-1:0] serdes_rx_data,
  output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
  output logic                  serdes_rx_valid,
  output logic [6:0]            slip_offset
);

  localparam int unsigned BlockWidth = DATA_WIDTH + HDR_WIDTH;
  localparam logic [6:0]  MaxOffset  = 7'd65;

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("eth_phy_10g_rx_bitslip: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_rx_bitslip: HDR_WIDTH must be 2");
  end

  logic [DATA_WIDTH-1:0]   w_data_in;
  logic [HDR_WIDTH-1:0]    w_hdr_in;
  logic [BlockWidth-1:0]   w_word;
  logic [2*BlockWidth-1:0] w_window;
  logic [2*BlockWidth-1:0] w_shifted;
  logic [BlockWidth-1:0]   w_aligned;

  logic [BlockWidth-1:0]   r_prev;
  logic [6:0]              r_offset;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [HDR_WIDTH-1:0]    r_hdr;
  logic                    r_valid;

  // Optional per-lane bit reversal on the way in, so the window always works
  // in wire order (bit 0 first).
  always_comb begin
    w_data_in = '0;
    w_hdr_in  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_data_in[i] = BIT_REVERSE ? serdes_rx_data_in[DATA_WIDTH-1-i] : serdes_rx_data_in[i];
    end
    for (int i = 0; i < HDR_WIDTH; i++) begin
      w_hdr_in[i] = BIT_REVERSE ? serdes_rx_hdr_in[HDR_WIDTH-1-i] : serdes_rx_hdr_in[i];
    end
  end

  // Older word sits in the low half, so offset 0 selects the previous word
  // and larger offsets walk forward in time into the current word.
  assign w_word    = {w_data_in, w_hdr_in};
  assign w_window  = {w_word, r_prev};
  assign w_shifted = w_window >> r_offset;
  assign w_aligned = w_shifted[BlockWidth-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev   <= '0;
      r_offset <= '0;
      r_data   <= '0;
      r_hdr    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= serdes_rx_valid_in;
      if (serdes_rx_valid_in) begin
        r_prev <= w_word;
        r_data <= w_aligned[BlockWidth-1:HDR_WIDTH];
        r_hdr  <= w_aligned[HDR_WIDTH-1:0];
      end
      // Wrapping 65 -> 0 repeats one block; frame sync is unlocked while slipping.
      if (serdes_rx_bitslip) begin
        r_offset <= (r_offset == MaxOffset) ? 7'd0 : r_offset + 7'd1;
      end
    end
  end

  // Output lanes are reversed back from registered state only.
  always_comb begin
    serdes_rx_data = '0;
    serdes_rx_hdr  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      serdes_rx_data[i] = BIT_REVERSE ? r_data[DATA_WIDTH-1-i] : r_data[i];
    end
    for (int i = 0; i < HDR_WIDTH; i++) begin
      serdes_rx_hdr[i] = BIT_REVERSE ? r_hdr[HDR_WIDTH-1-i] : r_hdr[i];
    end
  end

  assign serdes_rx_valid = r_valid;
  assign slip_offset     = r_offset;

endmodule
